reg_file_master: RTL and testbench

Command-driven access master for the 8 x 16 register file. Accepts single or burst read/write commands over a valid/ready command channel, drives the register file's RdEn/WrEn/Address/WrData port, captures RdData, and returns read beats over a valid/ready response channel. It sits between a processing block (or bus bridge) and the register file and handles the file's one-cycle registered read latency.

---
 rtl/reg_file_master.sv | 159 +++++++++++++++
 tb/tb_reg_file_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_master.sv
// Command-driven single/burst access master for an 8 x 16 register file.
// Sequences RdEn/WrEn against the file's one-cycle registered read and returns read beats over valid/ready.
module reg_file_master #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [ADDR-1:0]  cmd_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [WIDTH-1:0] wd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             RdEn,
  output logic             WrEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] RdData
);

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_REQ,
    RD_CAP,
    RD_RESP
  } state_t;

  state_t           state, nxtState;
  logic [ADDR-1:0]  curAddr, nxtCurAddr;
  logic [ADDR-1:0]  beatCnt, nxtBeatCnt;
  logic [ADDR-1:0]  nxtAddress;
  logic             nxtRdEn, nxtWrEn, nxtRdValid, nxtRdLast;
  logic [WIDTH-1:0] nxtWrData, nxtRdData;
  logic             lastBeat;

  // Wraps at the last entry, so 7 -> 0 simply continues the burst.
  function automatic logic [ADDR-1:0] incAddr(input logic [ADDR-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR'(1);
  endfunction

  assign cmd_ready = rst && (state == IDLE);
  assign wd_ready  = rst && (state == WRITE);
  assign busy      = (state != IDLE);
  assign lastBeat  = (beatCnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      curAddr  <= '0;
      beatCnt  <= '0;
      RdEn     <= 1'b0;
      WrEn     <= 1'b0;
      Address  <= '0;
      WrData   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      state    <= nxtState;
      curAddr  <= nxtCurAddr;
      beatCnt  <= nxtBeatCnt;
      RdEn     <= nxtRdEn;
      WrEn     <= nxtWrEn;
      Address  <= nxtAddress;
      WrData   <= nxtWrData;
      rd_valid <= nxtRdValid;
      rd_data  <= nxtRdData;
      rd_last  <= nxtRdLast;
    end
  end

  // RdEn/WrEn default low: each is a one-cycle strobe raised only on the edges below.
  always_comb begin
    nxtState   = state;
    nxtCurAddr = curAddr;
    nxtBeatCnt = beatCnt;
    nxtAddress = Address;
    nxtRdEn    = 1'b0;
    nxtWrEn    = 1'b0;
    nxtWrData  = WrData;
    nxtRdValid = rd_valid;
    nxtRdData  = rd_data;
    nxtRdLast  = rd_last;

    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          nxtCurAddr = cmd_addr;
          nxtBeatCnt = cmd_len;
          if (cmd_wr) begin
            nxtState = WRITE;
          end else begin
            nxtState   = RD_REQ;
            nxtRdEn    = 1'b1;
            nxtAddress = cmd_addr;
          end
        end
      end

      WRITE: begin
        if (wd_valid && wd_ready) begin
          nxtWrEn    = 1'b1;
          nxtAddress = curAddr;
          nxtWrData  = wd_data;
          if (lastBeat) begin
            nxtState = IDLE;
          end else begin
            nxtCurAddr = incAddr(curAddr);
            nxtBeatCnt = beatCnt - ADDR'(1);
          end
        end
      end

      RD_REQ: begin
        nxtState = RD_CAP;
      end

      RD_CAP: begin
        nxtRdData  = RdData;
        nxtRdValid = 1'b1;
        nxtRdLast  = lastBeat;
        nxtState   = RD_RESP;
      end

      RD_RESP: begin
        if (rd_valid && rd_ready) begin
          nxtRdValid = 1'b0;
          nxtRdLast  = 1'b0;
          if (lastBeat) begin
            nxtState = IDLE;
          end else begin
            nxtCurAddr = incAddr(curAddr);
            nxtBeatCnt = beatCnt - ADDR'(1);
            nxtRdEn    = 1'b1;
            nxtAddress = incAddr(curAddr);
            nxtState   = RD_REQ;
          end
        end
      end

      default: begin
        nxtState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_file_master.sv
// Scoreboard bench for reg_file_master against a registered 8 x 16 register file model.
// Expected beats come from an abstract array model of the file's contents.
module tb_reg_file_master;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int ADDR  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR-1:0]  cmd_addr, cmd_len;
  logic             wd_valid, wd_ready;
  logic [WIDTH-1:0] wd_data;
  logic             rd_valid, rd_ready, rd_last;
  logic [WIDTH-1:0] rd_data;
  logic             busy, RdEn, WrEn;
  logic [ADDR-1:0]  Address;
  logic [WIDTH-1:0] WrData, RdData;

  always #5 clk = ~clk;

  reg_file_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .RdEn(RdEn), .WrEn(WrEn), .Address(Address),
    .WrData(WrData), .RdData(RdData)
  );

  // Register file: registered read, no reset on contents.
  logic [WIDTH-1:0] fileMem [DEPTH];
  always @(posedge clk) begin
    if (WrEn) fileMem[Address] <= WrData;
    if (RdEn) RdData <= fileMem[Address];
  end

  typedef struct packed { logic [ADDR-1:0] addr; logic [WIDTH-1:0] data; } wrExp_t;
  typedef struct packed { logic [WIDTH-1:0] data; logic last; } rdExp_t;

  logic [WIDTH-1:0] refMem [DEPTH];
  logic [WIDTH-1:0] burstData [DEPTH];
  wrExp_t wrQ[$];
  rdExp_t rdQ[$];
  wrExp_t mWe;
  rdExp_t mRe;
  int nChecks = 0;
  int nFails  = 0;
  int rdyMode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rd_ready: 0 always high, 1 random, 2 held low
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdyMode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write strobe or a read beat.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (RdEn || WrEn) chk("rden_wren_exclusive", 32'(RdEn && WrEn), 32'd0);
      if (WrEn) begin
        chk("write_expected", 32'(wrQ.size() != 0), 32'd1);
        if (wrQ.size() != 0) begin
          mWe = wrQ.pop_front();
          chk("wr_address", 32'(Address), 32'(mWe.addr));
          chk("wr_data", 32'(WrData), 32'(mWe.data));
        end
      end
      if (rd_valid && rd_ready) begin
        chk("read_expected", 32'(rdQ.size() != 0), 32'd1);
        if (rdQ.size() != 0) begin
          mRe = rdQ.pop_front();
          chk("rd_data", 32'(rd_data), 32'(mRe.data));
          chk("rd_last", 32'(rd_last), 32'(mRe.last));
        end
      end
    end
  end

  task automatic sendCmd(input logic wr, input logic [ADDR-1:0] a, input logic [ADDR-1:0] l,
                         output logic ok);
    logic hs;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_len   = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      hs = cmd_ready;
      tick();
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = ADDR'($urandom);
    cmd_len   = ADDR'($urandom);
    chk("cmd_accepted", 32'(ok), 32'd1);
  endtask

  // mode 0: back-to-back beats; 1: two idle cycles between beats with cmd_valid probing; 2: random gaps
  task automatic writeBurst(input logic [ADDR-1:0] a, input logic [ADDR-1:0] l, input int mode);
    logic ok, hs;
    int gaps, waits;
    logic [ADDR-1:0] ba;
    sendCmd(1'b1, a, l, ok);
    if (!ok) return;
    for (int b = 0; b <= int'(l); b++) begin
      gaps = (mode == 1 && b > 0) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        wd_valid = 1'b0;
        wd_data  = WIDTH'($urandom);
        if (mode == 1) begin
          cmd_valid = 1'b1;
          cmd_wr    = 1'b0;
        end
        @(negedge clk);
        if (mode == 1) chk("cmd_ready_low_in_burst", 32'(cmd_ready), 32'd0);
        tick();
      end
      cmd_valid = 1'b0;
      wd_valid  = 1'b1;
      wd_data   = burstData[b];
      hs = 1'b0;
      waits = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        hs = wd_ready;
        tick();
        if (hs) break;
        waits++;
      end
      chk("wd_accepted", 32'(hs), 32'd1);
      if (mode == 0) chk("wd_ready_every_cycle", 32'(waits), 32'd0);
      if (hs) begin
        ba = ADDR'((int'(a) + b) % DEPTH);
        wrQ.push_back('{addr: ba, data: burstData[b]});
        refMem[ba] = burstData[b];
      end
    end
    wd_valid = 1'b0;
    wd_data  = WIDTH'($urandom);
  endtask

  task automatic readBurst(input logic [ADDR-1:0] a, input logic [ADDR-1:0] l, input logic stall);
    logic ok;
    int n, i, savedMode;
    logic [ADDR-1:0] ba;
    for (int b = 0; b <= int'(l); b++) begin
      ba = ADDR'((int'(a) + b) % DEPTH);
      rdQ.push_back('{data: refMem[ba], last: (b == int'(l))});
    end
    savedMode = rdyMode;
    if (stall) rdyMode = 2;
    sendCmd(1'b0, a, l, ok);
    if (!ok) begin
      rdQ.delete();
      rdyMode = savedMode;
      return;
    end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("rden_after_cmd", 32'(RdEn), 32'd1);
        chk("rd_req_address", 32'(Address), 32'(a));
      end
      if (rd_valid) break;
    end
    chk("read_latency", 32'(n), 32'd3);
    if (stall) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("stall_rd_valid", 32'(rd_valid), 32'd1);
        chk("stall_rd_data", 32'(rd_data), 32'(refMem[a]));
        chk("stall_no_rden", 32'(RdEn), 32'd0);
      end
      rdyMode = savedMode;
    end
    i = 0;
    while (rdQ.size() != 0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("read_beats_delivered", 32'(rdQ.size()), 32'd0);
    rdQ.delete();
    tick();
    chk("busy_after_last_read", 32'(busy), 32'd0);
  endtask

  task automatic resetMidBurst();
    logic ok;
    int i;
    rdyMode = 0;
    for (int b = 0; b < 4; b++) rdQ.push_back('{data: refMem[b], last: (b == 3)});
    sendCmd(1'b0, 3'd0, 3'd3, ok);
    i = 0;
    while (rdQ.size() > 3 && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("first_beat_before_reset", 32'(rdQ.size()), 32'd3);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
    tick();
    chk("rst_rden", 32'(RdEn), 32'd0);
    chk("rst_wren", 32'(WrEn), 32'd0);
    chk("rst_address", 32'(Address), 32'd0);
    chk("rst_wrdata", 32'(WrData), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wd_ready", 32'(wd_ready), 32'd0);
    rdQ.delete();
    rst = 1'b1;
    #1;
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_rden_after_reset", 32'(RdEn), 32'd0);
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR-1:0] ra, rl;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_rden", 32'(RdEn), 32'd0);
    chk("reset_wren", 32'(WrEn), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_wd_ready", 32'(wd_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Full-depth write then read also initialises every entry of the file.
    for (int i = 0; i < DEPTH; i++) burstData[i] = WIDTH'(16'h0100 + i);
    writeBurst(3'd0, 3'd7, 0);
    readBurst(3'd0, 3'd7, 1'b0);

    burstData[0] = 16'h000B;
    writeBurst(3'd3, 3'd0, 0);
    readBurst(3'd3, 3'd0, 1'b0);

    burstData[0] = 16'h1111; burstData[1] = 16'h2222;
    burstData[2] = 16'h3333; burstData[3] = 16'h4444;
    writeBurst(3'd6, 3'd3, 0);
    readBurst(3'd6, 3'd3, 1'b0);

    readBurst(3'd6, 3'd1, 1'b1);

    for (int i = 0; i < 4; i++) burstData[i] = WIDTH'($urandom);
    writeBurst(3'd2, 3'd3, 1);
    readBurst(3'd2, 3'd3, 1'b0);

    resetMidBurst();

    for (int t = 0; t < 40; t++) begin
      rdyMode = int'($urandom_range(0, 1));
      ra = ADDR'($urandom);
      rl = ADDR'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < DEPTH; i++) burstData[i] = WIDTH'($urandom);
        writeBurst(ra, rl, 2);
      end else begin
        readBurst(ra, rl, 1'b0);
      end
    end
    rdyMode = 0;

    repeat (4) tick();
    chk("writes_all_observed", 32'(wrQ.size()), 32'd0);
    for (int i = 0; i < DEPTH; i++) chk("file_contents", 32'(fileMem[i]), 32'(refMem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
